// File: rtl/edge_point_fifo.sv
// Edge-point extractor: tracks pixel (x, y), thresholds each pixel and queues
// edge coordinates in a first-word fall-through FIFO for the Hough voting stage.
module edge_point_fifo #(
  parameter int THRESH = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              nReset,
  input  logic              Clk,
  input  logic [7:0]        Pixel,
  input  logic              Line,
  input  logic              Frame,
  input  logic [7:0]        Width,
  output logic              PointValid,
  output logic [7:0]        PointX,
  output logic [7:0]        PointY,
  input  logic              PointReady,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow,
  output logic              FrameDone
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [7:0]              x_q, x_d, y_q, y_d;
  logic [DEPTH-1:0][15:0]  mem_q, mem_d;
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]         count_q, count_d;
  logic [15:0]             head_q, head_d;
  logic                    overflow_q, overflow_d;
  logic                    frame_done_q, frame_done_d;
  logic                    edge_pt, pop, push, drop, full;

  always_comb begin
    edge_pt = (Pixel >= 8'(THRESH)) && ((Width == 8'd0) || (x_q < Width));
    full    = (count_q == FULL_CNT);
    pop     = (count_q != '0) && PointReady;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push    = edge_pt && (!full || pop);
    drop    = edge_pt && full && !pop;

    x_d = x_q + 8'd1;
    y_d = y_q;
    if (Frame) begin
      x_d = 8'd0;
      y_d = 8'd0;
    end else if (Line) begin
      x_d = 8'd0;
      y_d = y_q + 8'd1;
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {x_q, y_q};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Next head comes straight from the push when it lands in the head slot.
    head_d = head_q;
    if (count_d != '0)
      head_d = (push && (rd_ptr_d == wr_ptr_q)) ? {x_q, y_q} : mem_q[rd_ptr_d];

    overflow_d   = Frame ? drop : (overflow_q | drop);
    frame_done_d = Frame;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      x_q          <= '0;
      y_q          <= '0;
      mem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign PointValid = (count_q != '0);
  assign PointX     = head_q[15:8];
  assign PointY     = head_q[7:0];
  assign Count      = count_q;
  assign Overflow   = overflow_q;
  assign FrameDone  = frame_done_q;

endmodule

// File: doc/edge_point_fifo.md
Name: edge_point_fifo

Overview:
- Sits in the pixel pipeline alongside the line-width measurement stage.
- Consumes the same one-pixel-per-clock stream (Pixel, Line, Frame) plus the measured Width value.
- Tracks the (x, y) coordinate of every pixel and thresholds each pixel to detect edge points.
- Buffers edge points in a FIFO and presents them to the downstream Hough voting stage over a valid/ready handshake.

Parameters:
- THRESH, 128: edge threshold; a pixel is an edge when Pixel >= THRESH.
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- ADDR_W, 4: log2(DEPTH).

Ports:
- nReset  in  1  asynchronous active-low reset
- Clk  in  1  clock; one pixel per cycle
- Pixel  in  8  pixel intensity, sampled every cycle
- Line  in  1  high on the last pixel of each line
- Frame  in  1  high on the last pixel of each frame; always coincides with Line
- Width  in  8  measured line length; 0 = not yet known
- PointValid  out  1  FIFO head valid
- PointX  out  8  x of head entry
- PointY  out  8  y of head entry
- PointReady  in  1  consumer accepts head when PointValid & PointReady
- Count  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH
- Overflow  out  1  sticky: an edge point was dropped this frame
- FrameDone  out  1  one-cycle pulse the cycle after a Frame pixel

Behaviour:
- Reset: nReset is asynchronous, active-low; clock is Clk. While reset is asserted:
  - x = y = 0; FIFO empty.
  - PointValid = 0, PointX = PointY = 0, Count = 0, Overflow = 0, FrameDone = 0.
- Reset mid-operation discards all FIFO contents and coordinates immediately.
- Coordinates:
  - The current pixel has coordinate (x, y).
  - Line = 0: x <= x + 1, with 8-bit wrap from 255 to 0.
  - Line = 1: x <= 0 and y <= y + 1, with 8-bit wrap.
  - Frame = 1: x <= 0 and y <= 0; Frame overrides the y increment.
- Edge qualify: edge = (Pixel >= THRESH) && (Width == 0 || x < Width), evaluated on the current pixel with its own (x, y).
- Push: an edge writes {x, y} at the FIFO tail on the same clock edge.
- Latency: an edge pixel sampled at edge n into an empty FIFO gives PointValid = 1 with that data after edge n.
- FIFO read side:
  - First-word fall-through; PointX/PointY always show the head entry.
  - When empty, PointValid = 0 and PointX/PointY hold their last value.
  - Pop occurs when PointValid & PointReady.
  - PointReady while empty is ignored.
- Full, push and pop in the same cycle: the push is accepted. Count stays at DEPTH and no drop occurs.
- Full, push without pop: the point is dropped and Overflow <= 1. FIFO contents are unchanged.
- Empty, push and pop in the same cycle: there is no pop, since PointValid = 0. The push proceeds normally.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers are ADDR_W bits and wrap modulo DEPTH; full/empty are derived from Count.
- Overflow:
  - Sticky within a frame.
  - On a Frame cycle, Overflow <= (drop occurring this cycle).
  - Otherwise Overflow <= Overflow | drop.
- FrameDone:
  - Registered copy of Frame: high exactly one cycle, on the cycle after a Frame pixel.
  - The FIFO is not flushed at frame boundaries; points from frame k drain ahead of frame k+1 points.
- Width is used combinationally on each cycle. A change to Width takes effect on the next pixel.

Test Plan:
1. Reset, then a 4x3 frame (Line every 4th cycle, Frame on pixel 12), Width = 4, all Pixel = 0 -> PointValid never rises; FrameDone pulses once, one cycle after pixel 12; x, y back to 0.
2. Same frame, Pixel = 200 only at (2,1), PointReady = 1 -> PointValid high for exactly one cycle, the cycle after that pixel, with PointX = 2, PointY = 1.
3. Width = 3, Pixel = 255 every cycle of a 4-wide line, PointReady = 0 -> 3 entries (0,0),(1,0),(2,0); x = 3 is rejected; Count = 3.
4. DEPTH = 16, 20 consecutive edge pixels with PointReady = 0 -> Count = 16; Overflow = 1 from the 17th pixel; first 16 coordinates retained in order.
5. FIFO full, PointReady = 1 and edge pixel every cycle -> one pop and one push per cycle, Count stays 16, Overflow stays 0.
6. Overflow = 1, then a Frame pixel with no drop -> Overflow = 0 the next cycle; assert nReset mid-frame with Count = 5 -> Count = 0 and PointValid = 0 immediately.
